// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler
//   Shares one LED-strip word serializer between two pixel-frame sources
//   (0 = letter renderer, 1 = overlay/status). Each frame is one zero start
//   word, NUM_PIXELS pixel words from the granted source, END_WORDS zero end
//   words, then HOLD_CYCLES idle cycles before the next arbitration.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   enable                  allows new frames (sampled in IDLE only)
//   req[1:0]                level-sensitive frame requests
//   grant[1:0]              one-hot owner of the active frame
//   srcN_data/valid/ready   pixel word handshake per source
//   word_data/valid/ready   word handshake towards the serializer
//   pixel_idx               next pixel index expected from the owner
//   letter_idx              current letter for source 0
//   frame_done              pulse on the cycle the last end word is accepted
//   busy                    state != IDLE
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for enable && req; arbitrates round robin
// START   | presenting the 32-bit zero start word
// PIXELS  | passing the owner's pixel words straight through
// END     | presenting END_WORDS zero end words
// HOLD    | idle gap of HOLD_CYCLES cycles, word_valid low

module matrix_frame_scheduler #(
  parameter int NUM_PIXELS  = 64,
  parameter int END_WORDS   = 2,
  parameter int HOLD_CYCLES = 1000,
  parameter int NUM_LETTERS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  input  logic [31:0] src0_data,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [31:0] src1_data,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [5:0]  pixel_idx,
  output logic [2:0]  letter_idx,
  output logic        frame_done,
  output logic        busy
);

  localparam int END_W     = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;
  localparam int HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  localparam logic [5:0]        PIX_LAST    = 6'(NUM_PIXELS - 1);
  localparam logic [END_W-1:0]  END_LAST    = END_W'(END_WORDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(HOLD_LOAD);
  localparam logic [2:0]        LETTER_LAST = 3'(NUM_LETTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_PIXELS = 3'd2,
    S_END    = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t            state;
  logic              rr_last;
  logic [END_W-1:0]  end_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              arb_win;
  logic              xfer;
  logic              end_last_word;

  // Winner index: with both requesting, the source that did not win last time.
  always_comb begin
    arb_win = 1'b0;
    if (req == 2'b11) begin
      arb_win = ~rr_last;
    end else begin
      arb_win = req[1];
    end
  end

  // Word path. Start/end words are constant zero and the pixel phase is a
  // zero-latency pass-through, so holding stable under backpressure falls
  // out of the owner holding its own word stable.
  always_comb begin
    word_data  = 32'd0;
    word_valid = 1'b0;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    case (state)
      S_START, S_END: begin
        word_valid = 1'b1;
      end
      S_PIXELS: begin
        if (grant[1]) begin
          word_data  = src1_data;
          word_valid = src1_valid;
          src1_ready = word_ready;
        end else begin
          word_data  = src0_data;
          word_valid = src0_valid;
          src0_ready = word_ready;
        end
      end
      default: begin
      end
    endcase
  end

  assign xfer          = word_valid && word_ready;
  assign end_last_word = (state == S_END) && (end_cnt == END_LAST);
  assign frame_done    = end_last_word && word_ready;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      grant      <= 2'b00;
      rr_last    <= 1'b1;
      pixel_idx  <= 6'd0;
      end_cnt    <= '0;
      hold_cnt   <= '0;
      letter_idx <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && (req != 2'b00)) begin
            grant   <= arb_win ? 2'b10 : 2'b01;
            rr_last <= arb_win;
            state   <= S_START;
          end
        end

        S_START: begin
          if (xfer) begin
            pixel_idx <= 6'd0;
            state     <= S_PIXELS;
          end
        end

        S_PIXELS: begin
          if (xfer) begin
            if (pixel_idx == PIX_LAST) begin
              pixel_idx <= 6'd0;
              end_cnt   <= '0;
              state     <= S_END;
            end else begin
              pixel_idx <= pixel_idx + 6'd1;
            end
          end
        end

        S_END: begin
          if (xfer) begin
            if (end_cnt == END_LAST) begin
              grant <= 2'b00;
              if (grant[0]) begin
                letter_idx <= (letter_idx == LETTER_LAST) ? 3'd0 : letter_idx + 3'd1;
              end
              if (HOLD_CYCLES == 0) begin
                state <= S_IDLE;
              end else begin
                hold_cnt <= HOLD_INIT;
                state    <= S_HOLD;
              end
            end else begin
              end_cnt <= end_cnt + 1'b1;
            end
          end
        end

        S_HOLD: begin
          // Down-counter: HOLD_CYCLES cycles spent here, including terminal count.
          if (hold_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
module tb_matrix_frame_scheduler;

  localparam int NPIX   = 64;
  localparam int NWORDS = NPIX + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic        reset_n, enable;
  logic [1:0]  req, grant;
  logic [31:0] src0_data, src1_data, word_data;
  logic        src0_valid, src0_ready, src1_valid, src1_ready;
  logic        word_valid, word_ready;
  logic [5:0]  pixel_idx;
  logic [2:0]  letter_idx;
  logic        frame_done, busy;
  logic        bp_on, bp_rdy, rdy_fix;

  assign src0_data  = 32'hE000_0000 + {26'd0, pixel_idx};
  assign src1_data  = 32'hB100_0000 + {26'd0, pixel_idx};
  assign word_ready = bp_on ? bp_rdy : rdy_fix;

  matrix_frame_scheduler dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .grant(grant),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .pixel_idx(pixel_idx), .letter_idx(letter_idx), .frame_done(frame_done), .busy(busy)
  );

  // second instance with no hold gap
  logic        h_reset_n;
  logic [1:0]  h_req, h_grant;
  logic [31:0] h_src0_data, h_word_data;
  logic        h_src0_ready, h_src1_ready, h_word_valid, h_frame_done, h_busy;
  logic [5:0]  h_pixel_idx;
  logic [2:0]  h_letter_idx;

  assign h_src0_data = 32'hE000_0000 + {26'd0, h_pixel_idx};

  matrix_frame_scheduler #(.HOLD_CYCLES(0)) dut_h0 (
    .clk(clk), .reset_n(h_reset_n), .enable(1'b1), .req(h_req), .grant(h_grant),
    .src0_data(h_src0_data), .src0_valid(1'b1), .src0_ready(h_src0_ready),
    .src1_data(32'd0), .src1_valid(1'b0), .src1_ready(h_src1_ready),
    .word_data(h_word_data), .word_valid(h_word_valid), .word_ready(1'b1),
    .pixel_idx(h_pixel_idx), .letter_idx(h_letter_idx), .frame_done(h_frame_done), .busy(h_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // random backpressure pattern
  always @(posedge clk) begin
    #1;
    bp_rdy = 1'(($urandom_range(0, 1)));
  end

  // transfer monitor: collects accepted words, checks stall stability and isolation
  logic [31:0] wq[$];
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev  = 32'd0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev) begin
        check_vec("stall_data", word_data, data_prev);
        check_vec("stall_valid", {31'd0, word_valid}, 32'd1);
      end
      if (word_valid && word_ready) wq.push_back(word_data);
      if (grant == 2'b01 && src1_valid) check_vec("iso_src1_ready", {31'd0, src1_ready}, 32'd0);
    end
    stall_prev = reset_n && word_valid && !word_ready;
    data_prev  = word_data;
  end

  task automatic wait_grant(output int n, output int idle_n);
    n = 0;
    idle_n = 0;
    wq.delete();
    while (grant == 2'b00 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (!busy) idle_n++;
    end
    check_vec("grant_seen", {31'd0, grant != 2'b00}, 32'd1);
  endtask

  task automatic finish_frame(input logic [31:0] base, input string tag);
    bit got;
    logic [31:0] exp;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    check_vec({tag, "_done"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    check_vec({tag, "_count"}, 32'(wq.size()), 32'(NWORDS));
    for (int k = 0; k < wq.size() && k < NWORDS; k++) begin
      exp = (k == 0 || k > NPIX) ? 32'd0 : base + 32'(k - 1);
      check_vec({tag, "_word"}, wq[k], exp);
    end
    check_vec({tag, "_grant_clr"}, {30'd0, grant}, 32'd0);
  endtask

  task automatic wait_pixel(input logic [5:0] p);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      if (grant != 2'b00 && pixel_idx == p) got = 1'b1;
    end
    check_vec("pixel_reach", {31'd0, got}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_grant"}, {30'd0, grant}, 32'd0);
    check_vec({tag, "_wvalid"}, {31'd0, word_valid}, 32'd0);
    check_vec({tag, "_wdata"}, word_data, 32'd0);
    check_vec({tag, "_rdy0"}, {31'd0, src0_ready}, 32'd0);
    check_vec({tag, "_rdy1"}, {31'd0, src1_ready}, 32'd0);
    check_vec({tag, "_pix"}, {26'd0, pixel_idx}, 32'd0);
    check_vec({tag, "_letter"}, {29'd0, letter_idx}, 32'd0);
    check_vec({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    check_vec({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [1:0]  rr_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [2:0]  rr_let   [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
  logic [31:0] rr_base  [4] = '{32'hE000_0000, 32'hB100_0000, 32'hE000_0000, 32'hB100_0000};
  logic [2:0]  wrap_let [4] = '{3'd1, 3'd2, 3'd3, 3'd0};

  initial begin
    int n, idle_n;
    bit got;
    reset_n = 1'b0; enable = 1'b0; req = 2'b00;
    src0_valid = 1'b1; src1_valid = 1'b1;
    rdy_fix = 1'b1; bp_on = 1'b0;
    h_reset_n = 1'b0; h_req = 2'b00;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // single frame from source 0, then hold gap to the next frame
    enable = 1'b1; req = 2'b01;
    wait_grant(n, idle_n);
    check_vec("single_grant", {30'd0, grant}, 32'h1);
    finish_frame(32'hE000_0000, "single");
    check_vec("single_letter", {29'd0, letter_idx}, 32'd1);
    wait_grant(n, idle_n);
    check_vec("hold_gap_ge", {31'd0, (n + 1) >= 1001}, 32'd1);
    check_vec("hold_idle_cycles", 32'(idle_n), 32'd1);
    finish_frame(32'hE000_0000, "second");
    check_vec("second_letter", {29'd0, letter_idx}, 32'd2);

    // round robin after reset, both requesting
    reset_n = 1'b0; req = 2'b11;
    #1;
    check_vec("rr_reset_letter", {29'd0, letter_idx}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_grant(n, idle_n);
      check_vec("rr_grant", {30'd0, grant}, {30'd0, rr_grant[f]});
      finish_frame(rr_base[f], "rr");
      check_vec("rr_letter", {29'd0, letter_idx}, {29'd0, rr_let[f]});
    end

    // backpressure on the serializer side
    req = 2'b01; bp_on = 1'b1;
    wait_grant(n, idle_n);
    check_vec("bp_grant", {30'd0, grant}, 32'h1);
    finish_frame(32'hE000_0000, "bp");
    check_vec("bp_letter", {29'd0, letter_idx}, 32'd3);
    bp_on = 1'b0;

    // req and enable dropped mid-frame: frame completes, then stays idle
    wait_grant(n, idle_n);
    wait_pixel(6'd20);
    req = 2'b00; enable = 1'b0;
    finish_frame(32'hE000_0000, "drop");
    check_vec("drop_letter_wrap", {29'd0, letter_idx}, 32'd0);
    repeat (1100) @(posedge clk);
    #1;
    check_vec("drop_idle_busy", {31'd0, busy}, 32'd0);
    check_vec("drop_idle_grant", {30'd0, grant}, 32'd0);

    // reset mid-frame, first grant afterwards goes to source 0
    enable = 1'b1; req = 2'b01;
    wait_grant(n, idle_n);
    wait_pixel(6'd30);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    req = 2'b11;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_grant(n, idle_n);
    check_vec("post_reset_grant", {30'd0, grant}, 32'h1);
    finish_frame(32'hE000_0000, "post_reset");
    check_vec("post_reset_letter", {29'd0, letter_idx}, 32'd1);
    req = 2'b00;

    // letter wrap with no hold gap
    @(posedge clk); #1;
    h_reset_n = 1'b1; h_req = 2'b01;
    for (int f = 0; f < 4; f++) begin
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (h_frame_done) got = 1'b1;
      end
      check_vec("h0_done", {31'd0, got}, 32'd1);
      @(posedge clk); #1;
      check_vec("h0_letter", {29'd0, h_letter_idx}, {29'd0, wrap_let[f]});
      check_vec("h0_idle", {31'd0, h_busy}, 32'd0);
      @(posedge clk); #1;
      check_vec("h0_restart", {30'd0, h_grant}, 32'h1);
      check_vec("h0_start_word", {31'd0, h_word_valid}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_frame_scheduler.md
Name: matrix_frame_scheduler

Overview:
- Controller that shares the LED-strip word serializer between two pixel-frame requesters: 0 = text/letter renderer, 1 = overlay/status source.
- Sequences each strip frame: one 32-bit zero start word, NUM_PIXELS 32-bit pixel words from the granted source, END_WORDS zero end words.
- Then holds for HOLD_CYCLES before the next arbitration.
- Tracks the current letter index for source 0 and sits between the font/colour pixel generators and the bit-level strip serializer.

Parameters:
- NUM_PIXELS, 64, pixel words per frame (8x8 matrix); must be ≥ 1.
- END_WORDS, 2, zero words appended after the pixels; must be ≥ 1.
- HOLD_CYCLES, 1000, idle clk cycles between frames; 0 means no hold.
- NUM_LETTERS, 4, letter count for source 0; letter_idx wraps at this value.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  high allows new frames to start; sampled only in IDLE.
- req  in  2  per-source frame request, level-sensitive.
- grant  out  2  one-hot owner of the current frame; 00 when no frame is active.
- src0_data  in  32  source 0 pixel word.
- src0_valid  in  1  source 0 word valid.
- src0_ready  out  1  source 0 word accepted.
- src1_data  in  32  source 1 pixel word.
- src1_valid  in  1  source 1 word valid.
- src1_ready  out  1  source 1 word accepted.
- word_data  out  32  word to the serializer.
- word_valid  out  1  word_data valid.
- word_ready  in  1  serializer accepts the word.
- pixel_idx  out  6  index of the next pixel word expected from the owner, 0..NUM_PIXELS-1.
- letter_idx  out  3  current letter for source 0.
- frame_done  out  1  one-cycle pulse on the cycle the last end word is accepted.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; every output is 0 (including grant, word_valid, src*_ready, word_data, pixel_idx, letter_idx, frame_done, busy); rr_last = 1, so source 0 wins first.
- Transfer: a word moves when word_valid && word_ready. word_data and word_valid are held stable while word_valid && !word_ready.
- IDLE: if enable && req≠00, pick the winner, set grant in the same edge, go to START.
  - Arbitration is round robin: if both sources request, take the one ≠ rr_last; otherwise take the single requester.
  - rr_last updates to the winner.
- START: word_valid=1, word_data=0. On transfer, go to PIXELS with pixel_idx=0.
- PIXELS: combinational pass-through, zero latency.
  - word_data = owner data, word_valid = owner valid.
  - owner ready = word_ready; the non-owner's ready = 0.
  - Each transfer increments pixel_idx.
  - The transfer at pixel_idx = NUM_PIXELS-1 goes to END with end counter = 0; pixel_idx returns to 0.
- END: word_valid=1, word_data=0. On the END_WORDS-th transfer:
  - pulse frame_done and clear grant;
  - if the owner was source 0, letter_idx advances (NUM_LETTERS-1 wraps to 0);
  - go to HOLD, or straight to IDLE if HOLD_CYCLES=0.
- HOLD: count HOLD_CYCLES clk cycles with word_valid=0, then go to IDLE.
  - Arbitration happens in IDLE, so the first possible START is HOLD_CYCLES+1 cycles after frame_done.
- req deassertion after grant is ignored; the frame always completes. The owner must keep supplying words.
- Source stalls (owner valid low) stall the frame indefinitely; no timeout.
- enable low mid-frame does not abort; it only blocks the next arbitration in IDLE.
- Reset mid-frame: immediate return to the reset state. The serializer sees word_valid drop and must restart itself.
- busy = (state ≠ IDLE).
- letter_idx width is 3 bits, so NUM_LETTERS ≤ 8.

Test Plan:
- Single frame: reset, enable=1, req=01, source 0 always valid with data = 0xE0000000+pixel, word_ready=1 → 67 transfers: 0x0, then 0xE0000000..0xE000003F, then 0x0, 0x0. frame_done on the 67th. letter_idx 0→1. Next START ≥1001 cycles later.
- Round robin: req=11 held continuously → grant sequence 01,10,01,10. letter_idx increments only after source 0 frames.
- Backpressure: word_ready toggles 1,0,0,1 randomly → word_data stable while stalled, no word lost or duplicated, still 67 words in order.
- Letter wrap: four source 0 frames with HOLD_CYCLES=0 → letter_idx 1,2,3,0. Each new START begins exactly one cycle after frame_done.
- Mid-frame events: drop req and enable at pixel_idx=20 → frame completes, then the block stays in IDLE. Separately, assert reset_n low at pixel_idx=30 → all outputs 0 immediately; after release, the first grant goes to source 0.
- Non-owner isolation: source 1 valid=1 during a source 0 frame → src1_ready stays 0 throughout, and no source 1 data appears on word_data.
